// File: rtl/ram_test.sv
// Single-port synchronous word RAM for the VDC VRAM, with a power-up zeroing sweep.
// Optional macro RAM_TEST_OUTREG_EN adds an output pipeline register (2-cycle read latency).
module ram_test #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q,
    output logic              busy
);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [ADDR_W-1:0] r_clearPtr;
    logic [ADDR_W-1:0] w_clearPtrNext;
    logic              w_busy;
    logic              w_memWe;
    logic [ADDR_W-1:0] w_memAddr;
    logic [DATA_W-1:0] w_memData;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    assign w_busy = (r_state == ST_CLEAR);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
            r_clearPtr <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_clearPtr <= w_clearPtrNext;
        end
    end

    // The sweep leaves on the edge that zeroes the last word, when the pointer wraps to 0.
    always_comb begin
        w_stateNext    = r_state;
        w_clearPtrNext = r_clearPtr;
        case (r_state)
            ST_CLEAR: begin
                w_clearPtrNext = r_clearPtr + 1'b1;
                if (&r_clearPtr) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                w_stateNext = ST_RUN;
            end
            default: begin
                w_stateNext = ST_RUN;
            end
        endcase
    end

    // One shared write port so the array maps onto a single-port block RAM.
    always_comb begin
        w_memWe   = !reset && (w_busy || wren);
        w_memAddr = w_busy ? r_clearPtr : address;
        w_memData = w_busy ? '0 : data;
    end

    always_ff @(posedge clock) begin
        if (w_memWe) begin
            r_mem[w_memAddr] <= w_memData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_busy) begin
            r_q <= '0;
        end else begin
            r_q <= r_mem[address];
        end
    end

`ifdef RAM_TEST_OUTREG_EN
    logic [DATA_W-1:0] r_qPipe;

    always_ff @(posedge clock) begin
        if (reset || w_busy) begin
            r_qPipe <= '0;
        end else begin
            r_qPipe <= r_q;
        end
    end

    assign q = r_qPipe;
`else
    assign q = r_q;
`endif

    assign busy = w_busy;

endmodule

// File: tb/tb_ram_test.sv
// Directed self-checking bench for ram_test: sweep timing, read/write, read-during-write,
// sweep write masking, mid-sweep reset and streaming access.
module tb_ram_test;

`ifdef RAM_TEST_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int SWEEP_LEN = 32768;
    localparam int SWEEP_BOUND = 40000;

    logic        clock;
    logic        reset;
    logic [14:0] address;
    logic [15:0] data;
    logic        wren;
    logic [15:0] q;
    logic        busy;

    int checkCount = 0;
    int errorCount = 0;

    ram_test #(
        .ADDR_W    (15),
        .DATA_W    (16),
        .INIT_CLEAR(1)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .address(address),
        .data   (data),
        .wren   (wren),
        .q      (q),
        .busy   (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change at a negedge; returns at the next negedge, one posedge later.
    task automatic applyStimulus(input logic [14:0] a, input logic [15:0] d, input logic we);
        address = a;
        data    = d;
        wren    = we;
        @(negedge clock);
    endtask

    task automatic readCheck(input string tag, input logic [14:0] a, input logic [15:0] expected);
        for (int k = 0; k < LAT; k++) begin
            applyStimulus(a, 16'h0000, 1'b0);
        end
        checkOutput(tag, {16'h0000, q}, {16'h0000, expected});
    endtask

    task automatic applyReset(input string tag);
        @(negedge clock);
        reset = 1'b1;
        wren  = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, "_q"}, {16'h0000, q}, 32'd0);
    endtask

    // Counts cycles with busy high; optionally hammers a write that must be ignored.
    task automatic waitSweep(input string tag, input logic holdWrite);
        int   n;
        logic qNonZero;
        n        = 0;
        qNonZero = 1'b0;
        while (busy === 1'b1 && n < SWEEP_BOUND) begin
            if (q !== 16'h0000) qNonZero = 1'b1;
            applyStimulus(15'h7FFF, 16'hFFFF, holdWrite);
            n++;
        end
        wren = 1'b0;
        checkOutput({tag, "_len"}, n, SWEEP_LEN);
        checkOutput({tag, "_qzero"}, {31'd0, qNonZero}, 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        wren    = 1'b0;
        address = '0;
        data    = '0;

        applyReset("rst1");
        waitSweep("sweep1", 1'b0);
        readCheck("clr_0000", 15'h0000, 16'h0000);
        readCheck("clr_4000", 15'h4000, 16'h0000);
        readCheck("clr_7fff", 15'h7FFF, 16'h0000);

        applyStimulus(15'h0123, 16'hBEEF, 1'b1);
        readCheck("wr_0123", 15'h0123, 16'hBEEF);

        // Same-edge write and read must return the old word, then the new one.
        applyStimulus(15'h0010, 16'h1111, 1'b1);
        readCheck("pre_0010", 15'h0010, 16'h1111);
        applyStimulus(15'h0010, 16'h2222, 1'b1);
        for (int k = 1; k < LAT; k++) begin
            applyStimulus(15'h0010, 16'h0000, 1'b0);
        end
        checkOutput("rdw_old", {16'h0000, q}, 32'h0000_1111);
        applyStimulus(15'h0010, 16'h0000, 1'b0);
        checkOutput("rdw_new", {16'h0000, q}, 32'h0000_2222);

        applyStimulus(15'h0001, 16'hA5A5, 1'b1);
        readCheck("wr_0001", 15'h0001, 16'hA5A5);

        for (int i = 0; i < 256; i++) begin
            applyStimulus(i[14:0], i[15:0] ^ 16'h5A5A, 1'b1);
        end
        for (int i = 0; i < 256 + LAT - 1; i++) begin
            int j;
            logic [14:0] a;
            a = (i < 256) ? i[14:0] : 15'h0000;
            applyStimulus(a, 16'h0000, 1'b0);
            j = i - LAT + 1;
            if (j >= 0 && j < 256) begin
                checkOutput("stream", {16'h0000, q}, {16'h0000, j[15:0] ^ 16'h5A5A});
            end
        end

        // Abort a sweep at word 100, then restart it from word 0.
        applyReset("rst2");
        for (int k = 0; k < 100; k++) begin
            applyStimulus(15'h0000, 16'h0000, 1'b0);
        end
        checkOutput("mid_busy", {31'd0, busy}, 32'd1);
        applyReset("rst3");
        waitSweep("sweep2", 1'b1);
        readCheck("ign_7fff", 15'h7FFF, 16'h0000);
        readCheck("clr_0001", 15'h0001, 16'h0000);
        readCheck("clr_0123", 15'h0123, 16'h0000);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
